decoder_3x8: RTL and testbench



---
 rtl/decoder_3x8.sv | 73 +++++++
 tb/tb_decoder_3x8.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/decoder_3x8.sv
// -----------------------------------------------------------------------------
// decoder_3x8
//   Registered 3-to-8 line decoder with one-hot outputs. The 3-bit select
//   {A2, A1, A0} is decoded and captured on every rising clk edge, so the D
//   lines are glitch-free and clock-aligned. There is no combinational path
//   from A to D.
//
// Ports
//   clk      in   1  system clock, rising-edge active
//   rst      in   1  asynchronous, active-high reset; forces all D lines to 0
//   A0..A2   in   1  select bits, A2 is the MSB
//   D0..D7   out  1  one-hot decoded lines; Dn = 1 iff the registered select
//                    equals n. All zero only during/after reset, or for a
//                    cycle in which the select was unknown.
// -----------------------------------------------------------------------------
module decoder_3x8 (
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5,
  output logic D6,
  output logic D7
);

  logic [2:0] w_sel;
  logic [7:0] w_dec;
  logic [7:0] r_dec;

  assign w_sel = {A2, A1, A0};

  // An unknown select matches none of the explicit items and falls into
  // the default, so an X/Z select registers all-zero rather than a
  // multi-hot pattern.
  always_comb begin
    w_dec = 8'h00;
    case (w_sel)
      3'd0:    w_dec = 8'h01;
      3'd1:    w_dec = 8'h02;
      3'd2:    w_dec = 8'h04;
      3'd3:    w_dec = 8'h08;
      3'd4:    w_dec = 8'h10;
      3'd5:    w_dec = 8'h20;
      3'd6:    w_dec = 8'h40;
      3'd7:    w_dec = 8'h80;
      default: w_dec = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec <= 8'h00;
    end else begin
      r_dec <= w_dec;
    end
  end

  assign D0 = r_dec[0];
  assign D1 = r_dec[1];
  assign D2 = r_dec[2];
  assign D3 = r_dec[3];
  assign D4 = r_dec[4];
  assign D5 = r_dec[5];
  assign D6 = r_dec[6];
  assign D7 = r_dec[7];

endmodule

// File: tb/tb_decoder_3x8.sv
// -----------------------------------------------------------------------------
// tb_decoder_3x8
//   Self-checking bench for decoder_3x8. Inputs are driven on the falling
//   edge and outputs sampled 1 time unit after the rising edge. Expected
//   values come from a reference model: D = 2**(4*A2 + 2*A1 + A0), or zero
//   while reset is applied.
// -----------------------------------------------------------------------------
module tb_decoder_3x8;

  logic clk;
  logic rst;
  logic A0, A1, A2;
  logic D0, D1, D2, D3, D4, D5, D6, D7;

  int total;
  int bad;

  decoder_3x8 dut (
    .clk (clk),
    .rst (rst),
    .A0  (A0),
    .A1  (A1),
    .A2  (A2),
    .D0  (D0),
    .D1  (D1),
    .D2  (D2),
    .D3  (D3),
    .D4  (D4),
    .D5  (D5),
    .D6  (D6),
    .D7  (D7)
  );

  // 20-time-unit clock period; rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [7:0] d_bus();
    return {D7, D6, D5, D4, D3, D2, D1, D0};
  endfunction

  // Reference model: select index by arithmetic, one line per index.
  function automatic logic [7:0] ref_decode(input int n, input bit in_rst);
    logic [7:0] one;
    one = 8'h01;
    if (in_rst) return 8'h00;
    return one << n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input int n);
    A2 = ((n / 4) % 2) != 0;
    A1 = ((n / 2) % 2) != 0;
    A0 = (n % 2) != 0;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  int sel_q;
  bit rst_q;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    set_sel(5);

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 chk("reset_async_initial", d_bus(), 8'h00);

    // Outputs stay low through clock edges while reset is held.
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      chk("reset_held", d_bus(), 8'h00);
    end

    // Release: first edge loads the select present (101 -> D5).
    @(negedge clk);
    rst = 1'b0;
    drive_edge();
    chk("reset_release_d5", d_bus(), ref_decode(5, 1'b0));

    // Exhaustive sweep, one select per period.
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      set_sel(n);
      drive_edge();
      chk($sformatf("sweep_%0d", n), d_bus(), ref_decode(n, 1'b0));
      chk($sformatf("sweep_onehot_%0d", n), 8'($countones(d_bus())), 8'd1);
    end

    // Registration: mid-cycle change must not reach D before the edge.
    @(negedge clk);
    set_sel(0);
    drive_edge();
    chk("reg_d0", d_bus(), ref_decode(0, 1'b0));
    @(negedge clk);
    set_sel(7);
    #1 chk("reg_hold_mid", d_bus(), ref_decode(0, 1'b0));
    drive_edge();
    chk("reg_d7", d_bus(), ref_decode(7, 1'b0));

    // Asynchronous reset between edges, then recovery to D3.
    @(negedge clk);
    set_sel(3);
    drive_edge();
    chk("async_pre_d3", d_bus(), ref_decode(3, 1'b0));
    #4 rst = 1'b1;
    #1 chk("async_mid_cycle", d_bus(), 8'h00);
    drive_edge();
    chk("async_held_edge", d_bus(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("async_release_no_edge", d_bus(), 8'h00);
    drive_edge();
    chk("async_recover_d3", d_bus(), ref_decode(3, 1'b0));

    // Held select: no toggling over many cycles.
    @(negedge clk);
    set_sel(6);
    for (int i = 0; i < 5; i++) begin
      drive_edge();
      chk("hold_d6", d_bus(), ref_decode(6, 1'b0));
    end

    // Random selects with occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      sel_q = int'($urandom_range(0, 7));
      rst_q = ($urandom_range(0, 99) < 4);
      set_sel(sel_q);
      rst = rst_q;
      drive_edge();
      chk("rand_value", d_bus(), ref_decode(sel_q, rst_q));
      if (!rst_q)
        chk("rand_onehot", 8'($countones(d_bus())), 8'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
